// File: rtl/reader_scheduler.sv
`timescale 1ns/1ps
// Round-robin front end for the AXI reader: accept in IDLE, start pulse next cycle, response one cycle after the done edge.
// One transaction in flight; others are held off by req_ready. Optional WAIT watchdog under READER_SCHED_TIMEOUT_EN.
module reader_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 40,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_error,
  output logic [ADDR_W-1:0]         rd_base_addr,
  output logic [LEN_W-1:0]          rd_len,
  output logic                      rd_init_txn,
  input  logic                      rd_txn_done,
  input  logic                      rd_error,
  output logic                      busy,
  output logic                      timeout_flag
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              gnt_vld;
  logic [GW-1:0]     gnt_idx;
  logic [GW-1:0]     cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              done_rise;
  logic              tmo_hit;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_len   = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
  // done_q keeps tracking the level through LAUNCH, so a done still high from the
  // previous transaction, or one rising alongside the start pulse, is not an edge.
  assign done_rise = rd_txn_done & ~done_q;

`ifdef READER_SCHED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign tmo_hit      = (state_q == WAIT) && !done_rise && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign tmo_d        = tmo_q | tmo_hit;
  assign timeout_flag = tmo_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    err_d        = err_q;
    done_d       = rd_txn_done;
    req_ready    = '0;
    resp_valid   = '0;
    resp_error   = 1'b0;
    rd_init_txn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          grant_d            = gnt_idx;
          last_grant_d       = gnt_idx;
          addr_d             = sel_addr;
          len_d              = sel_len;
          // a zero-length request never reaches the reader and reports an error
          err_d              = (sel_len == '0);
          state_d            = (sel_len == '0) ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        rd_init_txn = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          err_d   = rd_error;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        resp_error          = err_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign rd_base_addr = addr_q;
  assign rd_len       = len_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_reader_scheduler.sv
`timescale 1ns/1ps
// Randomised bench for reader_scheduler: a transaction-timeline reference model predicts every output each cycle.
module tb_reader_scheduler;
  localparam int NR  = 4;
  localparam int AW  = 40;
  localparam int LW  = 16;
  localparam int TMO = 100;

  logic           ACLK = 1'b0;
  logic           ARESETN;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]  resp_valid;
  logic           resp_error;
  logic [AW-1:0]  rd_base_addr;
  logic [LW-1:0]  rd_len;
  logic           rd_init_txn;
  logic           rd_txn_done;
  logic           rd_error;
  logic           busy;
  logic           timeout_flag;

  always #5 ACLK = ~ACLK;

  reader_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .resp_valid(resp_valid), .resp_error(resp_error),
    .rd_base_addr(rd_base_addr), .rd_len(rd_len),
    .rd_init_txn(rd_init_txn), .rd_txn_done(rd_txn_done), .rd_error(rd_error),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: one transaction at a time, described by the cycle numbers of its start pulse and response.
  bit            m_busy;
  int            m_last;
  int            m_g;
  int            m_init_cyc;
  int            m_resp_cyc;
  int            m_tmo_cyc;
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  bit            done_prev;
  int            acc_idx;
  int            n_init;
  bit            last_resp_err;
  int            grants[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_resp;
    int pick;
    exp_ready = '0;
    exp_resp  = '0;
    pick      = -1;
    if (m_busy && m_resp_cyc < 0 && cyc > m_init_cyc) begin
      if (rd_txn_done && !done_prev) begin
        m_resp_cyc = cyc + 1;
        m_err      = rd_error;
      end
`ifdef READER_SCHED_TIMEOUT_EN
      else if (cyc == m_init_cyc + TMO) begin
        m_resp_cyc = cyc + 1;
        m_err      = 1'b1;
        m_tmo_cyc  = cyc + 1;
      end
`endif
    end
    if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (pick < 0 && req_valid[c]) pick = c;
      end
    end
    if (pick >= 0) exp_ready[pick] = 1'b1;
    if (m_busy && cyc == m_resp_cyc) exp_resp[m_g] = 1'b1;

    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, m_busy);
    chk("rd_init_txn", rd_init_txn, m_busy && cyc == m_init_cyc);
    chk("resp_valid", resp_valid, exp_resp);
    chk("resp_error", resp_error, (exp_resp != '0) ? m_err : 1'b0);
    chk("timeout_flag", timeout_flag, (m_tmo_cyc >= 0) && (cyc >= m_tmo_cyc));
    if (m_busy) begin
      chk("rd_base_addr", rd_base_addr, m_addr);
      chk("rd_len", rd_len, m_len);
    end
    if (rd_init_txn) n_init++;
    if (resp_valid != '0) last_resp_err = resp_error;
    acc_idx = pick;

    if (m_busy && cyc == m_resp_cyc) begin
      m_busy = 1'b0;
    end else if (pick >= 0) begin
      m_busy = 1'b1;
      m_g    = pick;
      m_last = pick;
      m_addr = req_addr[pick*AW +: AW];
      m_len  = req_len[pick*LW +: LW];
      grants.push_back(pick);
      if (m_len == '0) begin
        m_init_cyc = -1;
        m_resp_cyc = cyc + 1;
        m_err      = 1'b1;
      end else begin
        m_init_cyc = cyc + 1;
        m_resp_cyc = -1;
      end
    end
    done_prev = rd_txn_done;
    cyc++;
  endtask

  // Entered and left 1ns after a rising edge; inputs set before the call are what that cycle sees.
  task automatic tick();
    #3;
    model_cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    ARESETN     = 1'b0;
    req_valid   = '0;
    rd_txn_done = 1'b0;
    rd_error    = 1'b0;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_init_txn", rd_init_txn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    chk("rst_base_addr", rd_base_addr, 0);
    chk("rst_len", rd_len, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN   = 1'b1;
    m_busy    = 1'b0;
    m_last    = NR - 1;
    m_tmo_cyc = -1;
    done_prev = 1'b0;
    acc_idx   = -1;
    grants.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_len[i*LW +: LW]   = l;
  endtask

  task automatic rand_len(output logic [LW-1:0] l);
    if ($urandom_range(0, 7) == 0) l = '0;
    else l = LW'($urandom_range(1, 200));
  endtask

  task automatic rand_stim(input int done_rate);
    logic [LW-1:0] l;
    for (int i = 0; i < NR; i++) begin
      if (acc_idx == i || !req_valid[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          rand_len(l);
          set_req(i, AW'({$urandom, $urandom}), l);
        end else begin
          req_valid[i] = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    if ($urandom_range(0, done_rate - 1) == 0) rd_txn_done = ~rd_txn_done;
    rd_error = 1'(($urandom_range(0, 1)));
  endtask

  initial begin
    int rr_exp [5];
    int n_before;
    rr_exp      = '{0, 1, 2, 3, 0};
    ARESETN     = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_len     = '0;
    rd_txn_done = 1'b0;
    rd_error    = 1'b0;
    n_init      = 0;
    last_resp_err = 1'b0;
    @(posedge ACLK);
    #1;
    do_reset();

    // single request from requester 0, reader done 40 cycles later without error
    n_init = 0;
    set_req(0, 40'h10_0000_00, 16'd16);
    req_addr[0 +: AW] = 40'h00_1000_0000;
    tick();
    req_valid = '0;
    ticks(40);
    rd_txn_done = 1'b1;
    tick();
    ticks(4);
    chk("single_init_count", n_init, 1);
    chk("single_resp_error", last_resp_err, 0);
    chk("single_grant", grants.size() > 0 ? grants[0] : -1, 0);

    // stale done held high into the next transaction, then a fresh edge carrying an error
    set_req(1, 40'h00_2000_0040, 16'd5);
    tick();
    req_valid = '0;
    ticks(10);
    chk("stale_still_busy", busy, 1);
    rd_txn_done = 1'b0;
    ticks(3);
    rd_txn_done = 1'b1;
    rd_error    = 1'b1;
    tick();
    rd_error = 1'b0;
    ticks(3);
    chk("rd_error_resp", last_resp_err, 1);

    // zero-length request from requester 2 never starts the reader
    last_resp_err = 1'b0;
    n_before = n_init;
    set_req(2, 40'h00_3000_0000, 16'd0);
    tick();
    req_valid = '0;
    ticks(3);
    chk("zero_no_init", n_init, n_before);
    chk("zero_resp_error", last_resp_err, 1);

    // reset while waiting on the reader, then all four requesters valid continuously
    rd_txn_done = 1'b0;
    set_req(0, 40'h00_4000_0000, 16'd8);
    tick();
    req_valid = '0;
    ticks(4);
    chk("mid_busy_before_rst", busy, 1);
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(40'h50_0000_0000 + i * 'h100), LW'(i + 1));
    for (int n = 0; n < 400 && grants.size() < 5; n++) begin
      if (acc_idx >= 0) req_len[acc_idx*LW +: LW] = LW'($urandom_range(1, 50));
      if ($urandom_range(0, 2) == 0) rd_txn_done = ~rd_txn_done;
      rd_error = 1'(($urandom_range(0, 1)));
      tick();
    end
    chk("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", grants.size() > i ? grants[i] : -1, rr_exp[i]);

`ifdef READER_SCHED_TIMEOUT_EN
    do_reset();
    set_req(3, 40'h00_6000_0000, 16'd4);
    tick();
    req_valid = '0;
    ticks(130);
    chk("tmo_flag_set", timeout_flag, 1);
    chk("tmo_resp_error", last_resp_err, 1);
    ticks(10);
    chk("tmo_flag_sticky", timeout_flag, 1);
`endif

    // randomised traffic with a toggling reader done level
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rand_stim((n < 2000) ? 6 : 20);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
